// File: rtl/l2_burst_responder_if.sv
// L1<->L2 block-fill channel: word-address request handshake plus a
// valid/ready data burst channel carrying one 2^W-bit beat per transfer.
interface l2_burst_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int W          = 7
);
  logic [ADDR_WIDTH-3:0] ADDR_TO_L2;
  logic                  ADDR_TO_L2_VALID;
  logic                  ADDR_TO_L2_READY;
  logic [(1<<W)-1:0]     DATA_FROM_L2;
  logic                  DATA_FROM_L2_VALID;
  logic                  DATA_FROM_L2_READY;
  logic                  DATA_FROM_L2_LAST;

  modport master (
    output ADDR_TO_L2, ADDR_TO_L2_VALID, DATA_FROM_L2_READY,
    input  ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID, DATA_FROM_L2_LAST
  );

  modport slave (
    input  ADDR_TO_L2, ADDR_TO_L2_VALID, DATA_FROM_L2_READY,
    output ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID, DATA_FROM_L2_LAST
  );
endinterface

// File: rtl/l2_burst_responder.sv
// L2 stand-in: queues block-fill requests, waits a fixed access latency per
// request, then returns each block as a multi-beat burst under backpressure.
module l2_burst_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int B               = 9,
  parameter int W               = 7,
  parameter int L2_DELAY        = 7,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WRAP_FIRST      = 1
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  l2_burst_responder_if.slave                  bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] OUTSTANDING
);
  localparam int AW       = ADDR_WIDTH - 2;
  localparam int BW       = B - W;
  localparam int L2_BURST = 1 << BW;
  localparam int WORDS    = 1 << (W - 5);
  localparam int CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DLW      = $clog2(L2_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_mem [MAX_OUTSTANDING];
  logic [DLW-1:0]  delay_reg [MAX_OUTSTANDING];
  logic [PW-1:0]   head_reg, tail_reg, head_succ;
  logic [CW-1:0]   count_reg;
  logic [BW-1:0]   beat_reg;

  logic            full, push, beat_fire, pop, head_due, succ_due;
  logic [AW-1:0]   head_addr, base_addr;
  logic [BW-1:0]   start_beat, beat_idx;
  logic [(1<<W)-1:0] beat_data;
  logic            addr_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full queue stays closed for the whole cycle, even if the head pops.
  assign full      = (count_reg == CW'(MAX_OUTSTANDING));
  assign push      = bus.ADDR_TO_L2_VALID && bus.ADDR_TO_L2_READY;
  assign beat_fire = bus.DATA_FROM_L2_VALID && bus.DATA_FROM_L2_READY;
  assign pop       = beat_fire && (beat_reg == BW'(L2_BURST - 1));
  assign head_succ = ptr_inc(head_reg);
  assign head_due  = (delay_reg[head_reg] == '0);
  assign succ_due  = (delay_reg[head_succ] == '0);

  assign bus.ADDR_TO_L2_READY = !full && !RST;
  assign OUTSTANDING          = count_reg;

  always_ff @(posedge CLK) begin
    if (push)
      addr_mem[tail_reg] <= bus.ADDR_TO_L2;
  end

  // Latency countdowns run every cycle regardless of data-channel stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        delay_reg[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (push && (tail_reg == PW'(i)))
          delay_reg[i] <= DLW'(L2_DELAY - 1);
        else if (delay_reg[i] != '0)
          delay_reg[i] <= delay_reg[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= S_IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_reg + CW'(push) - CW'(pop);
      if (push)
        tail_reg <= ptr_inc(tail_reg);
      if (pop)
        head_reg <= head_succ;
      if (beat_fire)
        beat_reg <= pop ? '0 : beat_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (count_reg != '0) state_next = head_due ? S_BURST : S_WAIT;
      S_WAIT:  if (head_due) state_next = S_BURST;
      S_BURST: begin
        if (pop) begin
          // A request pushed while the last entry drains becomes the new head.
          if (count_reg == CW'(1))
            state_next = push ? S_WAIT : S_IDLE;
          else
            state_next = succ_due ? S_BURST : S_WAIT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign head_addr   = addr_mem[head_reg];
  assign base_addr   = {head_addr[AW-1:B-5], {(B-5){1'b0}}};
  assign addr_unused = ^head_addr;

  generate
    if (WRAP_FIRST != 0) begin : g_wrap
      assign start_beat = head_addr[B-6:W-5];
    end else begin : g_linear
      assign start_beat = '0;
    end
  endgenerate

  assign beat_idx = start_beat + beat_reg;

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [AW-1:0]         word_addr;
      logic [ADDR_WIDTH-1:0] byte_addr;
      assign word_addr = base_addr + (AW'(beat_idx) << (W - 5)) + AW'(gi);
      assign byte_addr = {word_addr, 2'b00};
      assign beat_data[32*gi +: 32] = bus.DATA_FROM_L2_VALID ? 32'(byte_addr) : 32'h0;
    end
  endgenerate

  assign bus.DATA_FROM_L2_VALID = (state_reg == S_BURST);
  assign bus.DATA_FROM_L2_LAST  = bus.DATA_FROM_L2_VALID && (beat_reg == BW'(L2_BURST - 1));
  assign bus.DATA_FROM_L2       = beat_data;
endmodule
